mem_responder: RTL and testbench

- Synchronous word-addressed memory responder. It is the target side of the datapath's MAR/MDR memory interface.
- It serves mem_read / mem_write requests with a configurable wait-state latency and signals completion with a one-cycle done pulse.
- Data returned on a read feeds the MDR input mux; write data is taken from the MDR output.
- It replaces the combinational RAM model so that control-unit stepping can be exercised against a real multi-cycle memory.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 53 +++++
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, request
// op encoding, default datapath widths and the parity helper.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Even-parity bit: makes the total count of ones (word + bit) even.
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word array with write enable and a registered read
// port. With MEM_PARITY_EN defined, an even-parity column is stored beside the
// data and checked on every read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              inject,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port.
  // NOTE: the array itself has no reset; only the read register is cleared.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

`ifdef MEM_PARITY_EN
  logic par [DEPTH];

  // Parity column write; inject flips the stored bit for fault testing.
  always_ff @(posedge clock) begin
    if (we) par[idx] <= even_parity(wdata) ^ inject;
  end

  // Parity check registered alongside the read data.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)  par_err <= 1'b0;
    else if (re) par_err <= (even_parity(mem[idx]) != par[idx]);
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder serving level mem_read/mem_write requests
// with WAIT_CYCLES wait states and a one-cycle mem_done (or mem_err) pulse.
// Optional feature macro: MEM_PARITY_EN (parity column + inject_parity port).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_PARITY_EN
  input  logic              inject_parity,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  op_t               cap_op_q, cap_op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_q;
  logic              we, re;
  logic              in_range;

  assign in_range = ({1'b0, cap_addr_q} < DEPTH_L);

  // State, counter, capture and pulse registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_op_q   <= OP_READ;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
      cap_op_q   <= cap_op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_q       <= re;
    end
  end

  // Next-state, counter, capture and array-strobe logic.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    cap_op_d   = cap_op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    re         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          cap_addr_d = address;
          cap_data_d = data_in;
          cap_op_d   = mem_write ? OP_WRITE : OP_READ;
          cnt_d      = WAIT_L;
          busy_d     = 1'b1;
          state_d    = WAIT;
        end else if (mem_read && mem_write) begin
          // Conflicting request: reject without touching the array.
          err_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = RELEASE;
        end
      end

      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (in_range) begin
            re     = (cap_op_q == OP_READ);
            we     = (cap_op_q == OP_WRITE);
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // Wait for the requester to drop its level so it is served only once.
        if (!mem_read && !mem_write) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign mem_done = done_q;
  assign mem_busy = busy_q;

`ifdef MEM_PARITY_EN
  logic par_err;

  // A parity error only counts on the cycle right after a read access.
  assign mem_err = err_q | (rd_q & par_err);
`else
  assign mem_err = err_q;
`endif

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .clear   (clear),
    .we      (we),
    .re      (re),
    .idx     (cap_addr_q[IDX_W-1:0]),
    .wdata   (cap_data_q),
`ifdef MEM_PARITY_EN
    .inject  (inject_parity),
    .par_err (par_err),
`endif
    .rdata   (data_out)
  );

`ifndef MEM_PARITY_EN
  logic unused_rd;
  assign unused_rd = rd_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=256, WAIT_CYCLES=2).
module tb_mem_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] data_in = '0;
`ifdef MEM_PARITY_EN
  logic              inject_parity = 1'b0;
`endif
  logic [DATA_W-1:0] data_out;
  logic              mem_done;
  logic              mem_busy;
  logic              mem_err;

  int checks   = 0;
  int failures = 0;

  mem_responder #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (256),
    .WAIT_CYCLES (2)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .address       (address),
    .data_in       (data_in),
`ifdef MEM_PARITY_EN
    .inject_parity (inject_parity),
`endif
    .data_out      (data_out),
    .mem_done      (mem_done),
    .mem_busy      (mem_busy),
    .mem_err       (mem_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request, scramble the operands after the accept edge, wait
  // (bounded) for done/err, then drop the request and let the FSM return.
  task automatic req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, output int lat,
                     output logic saw_done, output logic saw_err,
                     output logic [DATA_W-1:0] rdata, output logic busy_after);
    mem_read  = rd;
    mem_write = wr;
    address   = a;
    data_in   = d;
    tick();
    address = ~a;
    data_in = ~d;
    lat = 0;
    while (!(mem_done || mem_err) && lat < 20) begin
      tick();
      lat++;
    end
    saw_done  = mem_done;
    saw_err   = mem_err;
    rdata     = data_out;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    busy_after = mem_busy;
  endtask

  initial begin
    int                lat;
    logic              sd, se, ba;
    logic [DATA_W-1:0] rd;
    int                ndone;
    logic              busy_dropped;

    // Reset: outputs all zero while clear is low.
    #2 clear = 1'b0;
    tick();
    tick();
    check("rst_data_out", data_out, 32'h0);
    check("rst_done", 32'(mem_done), 32'h0);
    check("rst_busy", 32'(mem_busy), 32'h0);
    check("rst_err", 32'(mem_err), 32'h0);
    #3 clear = 1'b1;
    tick();

    // Seed addr 5 with a known value.
    req(1'b0, 1'b1, 9'd5, 32'h1111_1111, lat, sd, se, rd, ba);
    check("seed5_lat", 32'(lat), 32'd3);
    check("seed5_done", 32'(sd), 32'h1);
    check("seed5_err", 32'(se), 32'h0);
    check("seed5_busy_after", 32'(ba), 32'h0);

    // Reset mid-WAIT aborts the write of 0xDEADBEEF to addr 5.
    mem_write = 1'b1;
    address   = 9'd5;
    data_in   = 32'hDEAD_BEEF;
    tick();
    tick();
    check("abort_busy_before", 32'(mem_busy), 32'h1);
    #2 clear = 1'b0;
    #1;
    check("abort_rst_busy", 32'(mem_busy), 32'h0);
    check("abort_rst_done", 32'(mem_done), 32'h0);
    check("abort_rst_err", 32'(mem_err), 32'h0);
    check("abort_rst_data", data_out, 32'h0);
    mem_write = 1'b0;
    #10 clear = 1'b1;
    tick();
    req(1'b1, 1'b0, 9'd5, 32'h0, lat, sd, se, rd, ba);
    check("abort_read5_data", rd, 32'h1111_1111);
    check("abort_read5_done", 32'(sd), 32'h1);

    // Basic write then read of addr 3.
    req(1'b0, 1'b1, 9'd3, 32'h1234_5678, lat, sd, se, rd, ba);
    check("wr3_lat", 32'(lat), 32'd3);
    check("wr3_done", 32'(sd), 32'h1);
    check("wr3_data_out_unchanged", rd, 32'h1111_1111);
    req(1'b1, 1'b0, 9'd3, 32'h0, lat, sd, se, rd, ba);
    check("rd3_lat", 32'(lat), 32'd3);
    check("rd3_done", 32'(sd), 32'h1);
    check("rd3_err", 32'(se), 32'h0);
    check("rd3_data", rd, 32'h1234_5678);

    // Done lasts exactly one cycle.
    check("done_one_cycle", 32'(mem_done), 32'h0);

    // Held read: exactly one done pulse, busy held until the request drops.
    mem_read = 1'b1;
    address  = 9'd3;
    tick();
    ndone = 0;
    busy_dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_done) ndone++;
      if (!mem_busy) busy_dropped = 1'b1;
    end
    check("held_done_count", 32'(ndone), 32'd1);
    check("held_busy_kept", 32'(busy_dropped), 32'h0);
    check("held_data", data_out, 32'h1234_5678);
    mem_read = 1'b0;
    tick();
    check("held_busy_release", 32'(mem_busy), 32'h0);

    // Illegal request: err in the cycle after accept, no done, no write.
    req(1'b1, 1'b1, 9'd3, 32'hAAAA_AAAA, lat, sd, se, rd, ba);
    check("ill_lat", 32'(lat), 32'd0);
    check("ill_err", 32'(se), 32'h1);
    check("ill_done", 32'(sd), 32'h0);
    check("ill_busy_after", 32'(ba), 32'h0);
    req(1'b1, 1'b0, 9'd3, 32'h0, lat, sd, se, rd, ba);
    check("ill_array_unchanged", rd, 32'h1234_5678);

    // Out of range: write 300 must not alias onto addr 44.
    req(1'b0, 1'b1, 9'd44, 32'h4444_4444, lat, sd, se, rd, ba);
    check("wr44_done", 32'(sd), 32'h1);
    req(1'b0, 1'b1, 9'd300, 32'hCAFE_F00D, lat, sd, se, rd, ba);
    check("oor_wr_lat", 32'(lat), 32'd3);
    check("oor_wr_err", 32'(se), 32'h1);
    check("oor_wr_done", 32'(sd), 32'h0);
    req(1'b1, 1'b0, 9'd44, 32'h0, lat, sd, se, rd, ba);
    check("oor_rd44_data", rd, 32'h4444_4444);
    check("oor_rd44_err", 32'(se), 32'h0);

    // Out-of-range read leaves data_out untouched.
    req(1'b1, 1'b0, 9'd400, 32'h0, lat, sd, se, rd, ba);
    check("oor_rd_err", 32'(se), 32'h1);
    check("oor_rd_done", 32'(sd), 32'h0);
    check("oor_rd_data_held", rd, 32'h4444_4444);

    // Boundary: last implemented word 255.
    req(1'b0, 1'b1, 9'd255, 32'hA5A5_5A5A, lat, sd, se, rd, ba);
    check("wr255_done", 32'(sd), 32'h1);
    req(1'b1, 1'b0, 9'd255, 32'h0, lat, sd, se, rd, ba);
    check("rd255_data", rd, 32'hA5A5_5A5A);

    // Back-to-back request right after return to IDLE.
    req(1'b1, 1'b0, 9'd5, 32'h0, lat, sd, se, rd, ba);
    check("b2b_rd5_lat", 32'(lat), 32'd3);
    check("b2b_rd5_data", rd, 32'h1111_1111);

`ifdef MEM_PARITY_EN
    // Parity fault: corrupted parity reported alongside done, data still loaded.
    inject_parity = 1'b1;
    req(1'b0, 1'b1, 9'd9, 32'h0000_0001, lat, sd, se, rd, ba);
    inject_parity = 1'b0;
    check("par_wr_done", 32'(sd), 32'h1);
    check("par_wr_err", 32'(se), 32'h0);
    mem_read = 1'b1;
    address  = 9'd9;
    tick();
    lat = 0;
    while (!mem_done && lat < 20) begin
      tick();
      lat++;
    end
    check("par_rd_done", 32'(mem_done), 32'h1);
    check("par_rd_err", 32'(mem_err), 32'h1);
    check("par_rd_data", data_out, 32'h0000_0001);
    mem_read = 1'b0;
    tick();
    check("par_err_one_cycle", 32'(mem_err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
